// File: rtl/mod_counter_bank_if.sv
// Bus bundle for mod_counter_bank: per-channel control/data in, counter values and tc out.
// io_sat exists only when MOD_COUNTER_SAT_EN is defined.
interface mod_counter_bank_if #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]       io_en;
  logic [CHANNELS-1:0]       io_dir;
  logic [CHANNELS-1:0]       io_mod;
  logic [CHANNELS*WIDTH-1:0] io_limit;
  logic [CHANNELS-1:0]       io_load;
  logic [CHANNELS*WIDTH-1:0] io_ld_val;
`ifdef MOD_COUNTER_SAT_EN
  logic [CHANNELS-1:0]       io_sat;
`endif
  logic [CHANNELS*WIDTH-1:0] io_dout;
  logic [CHANNELS-1:0]       io_tc;

  modport master (
`ifdef MOD_COUNTER_SAT_EN
    output io_sat,
`endif
    output io_en, io_dir, io_mod, io_limit, io_load, io_ld_val,
    input  io_dout, io_tc
  );

  modport slave (
`ifdef MOD_COUNTER_SAT_EN
    input  io_sat,
`endif
    input  io_en, io_dir, io_mod, io_limit, io_load, io_ld_val,
    output io_dout, io_tc
  );
endinterface

// File: rtl/mod_counter_bank.sv
// Bank of independent up/down modulo counters with load and registered terminal-count pulse.
// Optional saturation mode is compiled in with MOD_COUNTER_SAT_EN.
module mod_counter_bank #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 4
) (
  input logic               clock,
  input logic               reset,
  mod_counter_bank_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [CHANNELS*WIDTH-1:0] w_dout;
  logic [CHANNELS-1:0]       w_tc;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] r_count;
      logic             r_tc;
      logic [WIDTH-1:0] w_count_next;
      logic             w_tc_next;
      logic [WIDTH-1:0] w_limit;
      logic [WIDTH-1:0] w_top;
      logic             w_sat;

      assign w_limit = bus.io_limit[gi*WIDTH +: WIDTH];
      // Free-running mode behaves like a modulo limit of all ones.
      assign w_top   = bus.io_mod[gi] ? w_limit : {WIDTH{1'b1}};
`ifdef MOD_COUNTER_SAT_EN
      assign w_sat   = bus.io_sat[gi];
`else
      assign w_sat   = 1'b0;
`endif

      always_comb begin
        w_count_next = r_count;
        w_tc_next    = 1'b0;
        if (bus.io_load[gi]) begin
          w_count_next = bus.io_ld_val[gi*WIDTH +: WIDTH];
        end else if (bus.io_en[gi]) begin
          if (bus.io_dir[gi]) begin
            // >= so a loaded value above the limit still wraps (or holds when saturating).
            if (r_count >= w_top) begin
              w_tc_next = 1'b1;
              if (!w_sat) begin
                w_count_next = '0;
              end
            end else begin
              w_count_next = r_count + ONE;
            end
          end else begin
            if (r_count == '0) begin
              w_tc_next = 1'b1;
              if (!w_sat) begin
                w_count_next = w_top;
              end
            end else begin
              w_count_next = r_count - ONE;
            end
          end
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          r_count <= '0;
          r_tc    <= 1'b0;
        end else begin
          r_count <= w_count_next;
          r_tc    <= w_tc_next;
        end
      end

      assign w_dout[gi*WIDTH +: WIDTH] = r_count;
      assign w_tc[gi]                  = r_tc;
    end
  endgenerate

  assign bus.io_dout = w_dout;
  assign bus.io_tc   = w_tc;

endmodule

// File: tb/tb_mod_counter_bank.sv
// Directed self-checking bench for mod_counter_bank (default WIDTH=10, CHANNELS=4).
module tb_mod_counter_bank;
  localparam int W = 10;
  localparam int C = 4;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;

  mod_counter_bank_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  mod_counter_bank #(.WIDTH(W), .CHANNELS(C)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic en, input logic dir, input logic md,
                        input logic [W-1:0] lim, input logic ld, input logic [W-1:0] ldv);
    bus.io_en[ch]            = en;
    bus.io_dir[ch]           = dir;
    bus.io_mod[ch]           = md;
    bus.io_limit[ch*W +: W]  = lim;
    bus.io_load[ch]          = ld;
    bus.io_ld_val[ch*W +: W] = ldv;
  endtask

  task automatic test_reset();
    bus.io_en = '0; bus.io_dir = '0; bus.io_mod = '0; bus.io_limit = '0;
    bus.io_load = '0; bus.io_ld_val = '0;
`ifdef MOD_COUNTER_SAT_EN
    bus.io_sat = '0;
`endif
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    n_cmp++;
    if (bus.io_dout !== '0) begin n_bad++; $display("FAIL reset_dout got %h want 0", bus.io_dout); end
    n_cmp++;
    if (bus.io_tc !== '0) begin n_bad++; $display("FAIL reset_tc got %b want 0", bus.io_tc); end
    $display("reset: dout=%h tc=%b", bus.io_dout, bus.io_tc);
  endtask

  task automatic test_mod_up();
    int exp_d[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
    int exp_t[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    set_ch(0, 1'b1, 1'b1, 1'b1, 10'd5, 1'b0, 10'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      n_cmp++;
      if (bus.io_dout[0 +: W] !== W'(exp_d[k])) begin
        n_bad++; $display("FAIL mod_up_dout[%0d] got %0d want %0d", k, bus.io_dout[0 +: W], exp_d[k]);
      end
      n_cmp++;
      if (bus.io_tc[0] !== 1'(exp_t[k])) begin
        n_bad++; $display("FAIL mod_up_tc[%0d] got %b want %0d", k, bus.io_tc[0], exp_t[k]);
      end
      $display("mod_up k=%0d dout=%0d tc=%b", k, bus.io_dout[0 +: W], bus.io_tc[0]);
    end
  endtask

  task automatic test_mod_down();
    int exp_d[5] = '{3, 2, 1, 0, 3};
    int exp_t[5] = '{1, 0, 0, 0, 1};
    bus.io_en[0] = 1'b0;
    set_ch(1, 1'b1, 1'b0, 1'b1, 10'd3, 1'b0, 10'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (bus.io_dout[W +: W] !== W'(exp_d[k])) begin
        n_bad++; $display("FAIL mod_down_dout[%0d] got %0d want %0d", k, bus.io_dout[W +: W], exp_d[k]);
      end
      n_cmp++;
      if (bus.io_tc[1] !== 1'(exp_t[k])) begin
        n_bad++; $display("FAIL mod_down_tc[%0d] got %b want %0d", k, bus.io_tc[1], exp_t[k]);
      end
      $display("mod_down k=%0d dout=%0d tc=%b", k, bus.io_dout[W +: W], bus.io_tc[1]);
    end
    n_cmp++;
    if (bus.io_dout[0 +: W] !== 10'd2) begin
      n_bad++; $display("FAIL hold_ch0 got %0d want 2", bus.io_dout[0 +: W]);
    end
    bus.io_en[1] = 1'b0;
  endtask

  task automatic test_free_wrap();
    int exp_d[3] = '{1023, 0, 1};
    int exp_t[3] = '{0, 1, 0};
    set_ch(2, 1'b0, 1'b1, 1'b0, 10'd0, 1'b1, 10'd1022);
    step();
    n_cmp++;
    if (bus.io_dout[2*W +: W] !== 10'd1022 || bus.io_tc[2] !== 1'b0) begin
      n_bad++; $display("FAIL free_load got %0d/%b want 1022/0", bus.io_dout[2*W +: W], bus.io_tc[2]);
    end
    set_ch(2, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0, 10'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (bus.io_dout[2*W +: W] !== W'(exp_d[k]) || bus.io_tc[2] !== 1'(exp_t[k])) begin
        n_bad++; $display("FAIL free_wrap[%0d] got %0d/%b want %0d/%0d", k,
                          bus.io_dout[2*W +: W], bus.io_tc[2], exp_d[k], exp_t[k]);
      end
      $display("free_wrap k=%0d dout=%0d tc=%b", k, bus.io_dout[2*W +: W], bus.io_tc[2]);
    end
    // Load and enable together: load wins and tc stays low.
    set_ch(2, 1'b1, 1'b1, 1'b0, 10'd0, 1'b1, 10'd1023);
    step();
    n_cmp++;
    if (bus.io_dout[2*W +: W] !== 10'd1023 || bus.io_tc[2] !== 1'b0) begin
      n_bad++; $display("FAIL load_vs_en got %0d/%b want 1023/0", bus.io_dout[2*W +: W], bus.io_tc[2]);
    end
    bus.io_en[2] = 1'b0; bus.io_load[2] = 1'b0;
  endtask

  task automatic test_load_over_limit();
    set_ch(0, 1'b0, 1'b1, 1'b1, 10'd5, 1'b1, 10'd2);
    set_ch(1, 1'b0, 1'b0, 1'b1, 10'd3, 1'b1, 10'd1);
    set_ch(2, 1'b0, 1'b1, 1'b0, 10'd0, 1'b1, 10'd100);
    set_ch(3, 1'b0, 1'b1, 1'b1, 10'd5, 1'b1, 10'd9);
    step();
    n_cmp++;
    if (bus.io_dout !== {10'd9, 10'd100, 10'd1, 10'd2} || bus.io_tc !== 4'b0000) begin
      n_bad++; $display("FAIL multi_load got %h/%b want %h/0000", bus.io_dout, bus.io_tc,
                        {10'd9, 10'd100, 10'd1, 10'd2});
    end
    bus.io_load = '0;
    bus.io_en   = 4'b1111;
    step();
    n_cmp++;
    if (bus.io_dout !== {10'd0, 10'd101, 10'd0, 10'd3} || bus.io_tc !== 4'b1000) begin
      n_bad++; $display("FAIL over_limit got %h/%b want %h/1000", bus.io_dout, bus.io_tc,
                        {10'd0, 10'd101, 10'd0, 10'd3});
    end
    $display("over_limit: dout=%h tc=%b", bus.io_dout, bus.io_tc);
    bus.io_en = '0;
  endtask

  task automatic test_limit_zero();
    set_ch(0, 1'b1, 1'b1, 1'b1, 10'd0, 1'b0, 10'd0);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) bus.io_dir[0] = 1'b0;
      step();
      n_cmp++;
      if (bus.io_dout[0 +: W] !== 10'd0 || bus.io_tc[0] !== 1'b1) begin
        n_bad++; $display("FAIL limit_zero[%0d] got %0d/%b want 0/1", k, bus.io_dout[0 +: W], bus.io_tc[0]);
      end
      $display("limit_zero k=%0d dout=%0d tc=%b", k, bus.io_dout[0 +: W], bus.io_tc[0]);
    end
    bus.io_en[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_ch(0, 1'b0, 1'b1, 1'b1, 10'd5, 1'b1, 10'd3);
    step();
    set_ch(0, 1'b1, 1'b1, 1'b1, 10'd5, 1'b0, 10'd0);
    step();
    n_cmp++;
    if (bus.io_dout[0 +: W] !== 10'd4) begin
      n_bad++; $display("FAIL pre_reset got %0d want 4", bus.io_dout[0 +: W]);
    end
    set_ch(0, 1'b1, 1'b1, 1'b1, 10'd5, 1'b1, 10'd7);
    bus.io_en = 4'b1111;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (bus.io_dout !== '0 || bus.io_tc !== '0) begin
      n_bad++; $display("FAIL reset_mid got %h/%b want 0/0", bus.io_dout, bus.io_tc);
    end
    $display("reset_mid: dout=%h tc=%b", bus.io_dout, bus.io_tc);
    bus.io_en = '0; bus.io_load = '0;
  endtask

`ifdef MOD_COUNTER_SAT_EN
  task automatic test_sat();
    int exp_d[4] = '{1, 2, 2, 2};
    int exp_t[4] = '{0, 0, 1, 1};
    int dn_d[2]  = '{0, 0};
    int dn_t[2]  = '{0, 1};
    bus.io_sat[0] = 1'b1;
    set_ch(0, 1'b1, 1'b1, 1'b1, 10'd2, 1'b0, 10'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (bus.io_dout[0 +: W] !== W'(exp_d[k]) || bus.io_tc[0] !== 1'(exp_t[k])) begin
        n_bad++; $display("FAIL sat_up[%0d] got %0d/%b want %0d/%0d", k,
                          bus.io_dout[0 +: W], bus.io_tc[0], exp_d[k], exp_t[k]);
      end
      $display("sat_up k=%0d dout=%0d tc=%b", k, bus.io_dout[0 +: W], bus.io_tc[0]);
    end
    set_ch(0, 1'b0, 1'b0, 1'b1, 10'd2, 1'b1, 10'd1);
    step();
    set_ch(0, 1'b1, 1'b0, 1'b1, 10'd2, 1'b0, 10'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if (bus.io_dout[0 +: W] !== W'(dn_d[k]) || bus.io_tc[0] !== 1'(dn_t[k])) begin
        n_bad++; $display("FAIL sat_down[%0d] got %0d/%b want %0d/%0d", k,
                          bus.io_dout[0 +: W], bus.io_tc[0], dn_d[k], dn_t[k]);
      end
      $display("sat_down k=%0d dout=%0d tc=%b", k, bus.io_dout[0 +: W], bus.io_tc[0]);
    end
    bus.io_en = '0; bus.io_sat = '0;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    test_reset();
    test_mod_up();
    test_mod_down();
    test_free_wrap();
    test_load_over_limit();
    test_limit_zero();
    test_reset_mid();
`ifdef MOD_COUNTER_SAT_EN
    test_sat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mod_counter_bank.md
# mod_counter_bank

Bank of CHANNELS independent WIDTH-bit up/down counters, each with programmable modulo limit, synchronous parallel load and a registered terminal-count pulse. Successor to the single-channel 10-bit modulo counter: generalised in width and channel count, symmetric modulo wrap in both directions, plus load and wrap signalling. Used wherever several event or timebase counters share one clock domain.

## Interface
Parameters:
- WIDTH, 10, counter width per channel (>=2).
- CHANNELS, 4, number of independent counters (>=1).

Ports (channel i occupies bit i of 1-bit-per-channel buses and bits [i*WIDTH +: WIDTH] of data buses):
- clock  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, synchronous, active-high.
- io_en  input  CHANNELS  per-channel count enable.
- io_dir  input  CHANNELS  1 = count up, 0 = count down.
- io_mod  input  CHANNELS  1 = modulo limit active, 0 = free-running 2^WIDTH.
- io_limit  input  CHANNELS*WIDTH  per-channel modulo limit (inclusive top value).
- io_load  input  CHANNELS  per-channel synchronous load strobe.
- io_ld_val  input  CHANNELS*WIDTH  per-channel load value.
- io_sat  input  CHANNELS  1 = saturate instead of wrap (present only with MOD_COUNTER_SAT_EN).
- io_dout  output  CHANNELS*WIDTH  per-channel counter value (registered).
- io_tc  output  CHANNELS  per-channel terminal-count pulse (registered).

## Operation
- Channels fully independent; no cross-channel interaction.
- Per-channel priority each cycle: reset > load > enable > hold.
- reset: count = 0, tc = 0 for all channels.
- load=1: count = ld_val (any value, may exceed limit); tc = 0; en ignored.
- en=1, dir=1 (up):
  - mod=1 and count >= limit: count = 0, wrap event.
  - mod=0 and count == 2^WIDTH-1: count = 0, wrap event.
  - otherwise count + 1.
- en=1, dir=0 (down):
  - count == 0: count = limit if mod=1, else 2^WIDTH-1; wrap event.
  - otherwise count - 1 (mod=1 with count > limit decrements normally).
- en=0, load=0: count holds; tc = 0.
- tc = 1 for exactly the cycle following each wrap event, else 0.
- Arithmetic modulo 2^WIDTH; limit compare unsigned, WIDTH bits; limit = 0 with mod=1 keeps count at 0 and wraps (tc=1) every enabled cycle in either direction.
- io_limit, io_mod and io_dir sampled every cycle; changing them mid-count takes effect on the next enabled step, no state cleared.

## Timing
- All outputs registered; no combinational input-to-output path.
- Latency 1 cycle: inputs at edge N -> io_dout/io_tc valid after edge N.
- tc aligned with the wrapped dout value (same cycle dout shows 0 or limit).
- Back-to-back wraps with en held produce tc on consecutive cycles.
- Reset mid-count: next cycle dout = 0, tc = 0, regardless of load/en.
- Reset values: io_dout = 0 all channels, io_tc = 0 all channels.

## Configuration
- MOD_COUNTER_SAT_EN defined: io_sat port present. Channel with sat=1 never wraps: up holds at limit (mod=1) or 2^WIDTH-1 (mod=0); down holds at 0. tc = 1 the cycle after any enabled step blocked at the boundary (including the step that reaches it? no: only blocked steps). Up with mod=1 and count > limit holds count unchanged and signals tc. Load unaffected.
- Not defined: io_sat absent, wrap behaviour always, no saturation logic synthesised.

## Test plan
- Reset then channel 0 en=1, dir=1, mod=1, limit=5 for 8 cycles -> dout 1,2,3,4,5,0,1,2; tc=1 only with the 0.
- Channel 1 dir=0, mod=1, limit=3, from 0, 5 cycles -> dout 3,2,1,0,3; tc=1 with the first and last 3.
- Channel 2 mod=0, load 1022 then en up 3 cycles -> 1022,1023,0,1; tc=1 with 0; load with en=1 same cycle -> loaded value wins, tc=0.
- Channel 3 load 9 with limit=5, mod=1, up one step -> dout 0, tc=1; concurrently channels 0-2 counting unaffected.
- Assert reset while channel 0 at 4 with en=1, load=1 -> next cycle all dout=0, tc=0.
- MOD_COUNTER_SAT_EN, sat=1, up, limit=2 from 0, 4 cycles -> 1,2,2,2; tc=0,0,1,1; down from 1 -> 0,0 with tc=0,1.
